display_scanner: RTL and testbench

Responder-side driver for the touchscreen display-slot protocol: it walks `display_number` over the slots, samples each slot's `display_valid`/`display_name`/`display_value` answer from the user logic, and serialises the slot as ASCII characters to the LCD text writer over a valid/ready handshake. It sits between the user's display case-statement and the glyph/LCD writer inside `lcd_module`, replacing ad-hoc scanning with one deterministic frame sequencer.

---
 rtl/display_scan_pkg.sv | 29 ++
 rtl/slot_formatter.sv | 62 ++++++
 rtl/display_scanner.sv | 147 ++++++++++++++
 tb/tb_display_scanner.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// rtl/display_scan_pkg.sv - shared types and helpers for the display slot scanner
// Contents:
//   scan_state_t     frame sequencer states
//   SLOT_CHARS       characters emitted per slot (name, colon, 8 hex digits)
//   ASCII_SPACE/COLON fixed glyphs used by the slot layout
//   nibble_to_ascii  4-bit value to upper-case hex ASCII digit
package display_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_CAPT = 3'd3,
      ST_EMIT = 3'd4
   } scan_state_t;

   localparam int         SLOT_CHARS  = 14;
   localparam logic [3:0] LAST_POS    = 4'(SLOT_CHARS - 1);
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_COLON = 8'h3A;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return 8'h37 + {4'h0, nib};   // 0xA + 0x37 = 'A'
   endfunction

endpackage

// File: rtl/slot_formatter.sv
// rtl/slot_formatter.sv - combinational slot-to-ASCII character mapper
// Ports:
//   valid  in  1   slot in use; when low every position renders as a space
//   name   in  40  five ASCII chars, [39:32] leftmost; 0x00 renders as space
//   value  in  32  rendered as 8 upper-case hex digits, MSB nibble first
//   pos    in  4   character position within the slot, 0..13
//   code   out 8   ASCII code for that position
module slot_formatter
   import display_scan_pkg::*;
(
   input  logic        valid,
   input  logic [39:0] name,
   input  logic [31:0] value,
   input  logic [3:0]  pos,
   output logic [7:0]  code
);

   logic [7:0] name_byte;
   logic [3:0] nib;

   always_comb begin
      name_byte = 8'h00;
      case (pos)
         4'd0:    name_byte = name[39:32];
         4'd1:    name_byte = name[31:24];
         4'd2:    name_byte = name[23:16];
         4'd3:    name_byte = name[15:8];
         4'd4:    name_byte = name[7:0];
         default: name_byte = 8'h00;
      endcase
   end

   always_comb begin
      nib = 4'h0;
      case (pos)
         4'd6:    nib = value[31:28];
         4'd7:    nib = value[27:24];
         4'd8:    nib = value[23:20];
         4'd9:    nib = value[19:16];
         4'd10:   nib = value[15:12];
         4'd11:   nib = value[11:8];
         4'd12:   nib = value[7:4];
         4'd13:   nib = value[3:0];
         default: nib = 4'h0;
      endcase
   end

   always_comb begin
      code = ASCII_SPACE;
      if (!valid)
         code = ASCII_SPACE;               // unused slot blanks any stale text
      else if (pos <= 4'd4)
         code = (name_byte == 8'h00) ? ASCII_SPACE : name_byte;
      else if (pos == 4'd5)
         code = ASCII_COLON;
      else if (pos <= LAST_POS)
         code = nibble_to_ascii(nib);
      else
         code = ASCII_SPACE;
   end

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - display slot frame sequencer and character serialiser
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   scan_en             level; frames run back-to-back while high
//   display_number      slot requested from the user logic, 0 = none
//   display_valid/name/value  user answer for the requested slot
//   char_valid/ready    character handshake towards the LCD text writer
//   char_code/slot/pos  ASCII code, slot number and position of the character
//   frame_done          one-cycle pulse after the last character of a frame
//   busy                high from frame start until frame_done
module display_scanner
   import display_scan_pkg::*;
#(
   parameter int NUM_SLOTS = 44,
   parameter int RESP_LAT  = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        scan_en,
   output logic [5:0]  display_number,
   input  logic        display_valid,
   input  logic [39:0] display_name,
   input  logic [31:0] display_value,
   output logic        char_valid,
   input  logic        char_ready,
   output logic [7:0]  char_code,
   output logic [5:0]  char_slot,
   output logic [3:0]  char_pos,
   output logic        frame_done,
   output logic        busy
);

   localparam int         LAT_W     = (RESP_LAT < 2) ? 1 : $clog2(RESP_LAT + 1);
   localparam logic [5:0] LAST_SLOT = 6'(NUM_SLOTS);

   scan_state_t      state;
   logic [5:0]       slot;
   logic [LAT_W-1:0] lat_cnt;
   logic             cap_valid;
   logic [39:0]      cap_name;
   logic [31:0]      cap_value;

   logic             fmt_valid;
   logic [39:0]      fmt_name;
   logic [31:0]      fmt_value;
   logic [3:0]       fmt_pos;
   logic [7:0]       fmt_code;
   logic             xfer;

   // In CAPT the formatter looks at the live answer so position 0 can be
   // registered on the same edge that captures the slot; in EMIT it looks
   // ahead one position from the captured copy.
   always_comb begin
      fmt_valid = cap_valid;
      fmt_name  = cap_name;
      fmt_value = cap_value;
      fmt_pos   = char_pos + 4'd1;
      if (state == ST_CAPT) begin
         fmt_valid = display_valid;
         fmt_name  = display_name;
         fmt_value = display_value;
         fmt_pos   = 4'd0;
      end
   end

   assign xfer = char_valid && char_ready;

   slot_formatter u_fmt (
      .valid (fmt_valid),
      .name  (fmt_name),
      .value (fmt_value),
      .pos   (fmt_pos),
      .code  (fmt_code)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         slot           <= 6'd1;
         lat_cnt        <= '0;
         cap_valid      <= 1'b0;
         cap_name       <= '0;
         cap_value      <= '0;
         display_number <= 6'd0;
         char_valid     <= 1'b0;
         char_code      <= 8'h00;
         char_slot      <= 6'd0;
         char_pos       <= 4'd0;
         frame_done     <= 1'b0;
         busy           <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               display_number <= 6'd0;
               if (scan_en) begin
                  slot  <= 6'd1;
                  busy  <= 1'b1;
                  state <= ST_REQ;
               end
            end
            ST_REQ: begin
               display_number <= slot;
               lat_cnt        <= LAT_W'(RESP_LAT);
               state          <= ST_WAIT;
            end
            ST_WAIT: begin
               // Leaving on count 1 keeps WAIT exactly RESP_LAT cycles long.
               lat_cnt <= lat_cnt - 1'b1;
               if (lat_cnt == LAT_W'(1))
                  state <= ST_CAPT;
            end
            ST_CAPT: begin
               cap_valid  <= display_valid;
               cap_name   <= display_name;
               cap_value  <= display_value;
               char_valid <= 1'b1;
               char_code  <= fmt_code;
               char_slot  <= slot;
               char_pos   <= 4'd0;
               state      <= ST_EMIT;
            end
            ST_EMIT: begin
               if (xfer) begin
                  if (char_pos == LAST_POS) begin
                     char_valid <= 1'b0;
                     if (slot == LAST_SLOT) begin
                        frame_done     <= 1'b1;
                        busy           <= 1'b0;
                        display_number <= 6'd0;
                        state          <= ST_IDLE;
                     end else begin
                        slot  <= slot + 6'd1;
                        state <= ST_REQ;
                     end
                  end else begin
                     char_pos  <= char_pos + 4'd1;
                     char_code <= fmt_code;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - self-checking bench for display_scanner
module tb_display_scanner;

   typedef struct {
      logic [5:0] slot;
      logic [3:0] pos;
      logic [7:0] code;
   } vec_t;

   typedef struct {
      logic [5:0] slot;
      logic [3:0] pos;
      logic [7:0] code;
      int         cyc;
   } xfer_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // user display case statement: {valid, name, value}
   function automatic logic [72:0] user_ans(input logic [5:0] n);
      case (n)
         6'd1:    return {1'b1, "SRC_1", 32'h1234ABCD};
         6'd3:    return {1'b1, "AB", 24'h000000, 32'h00000000};
         default: return {1'b0, "stale", 32'hDEADBEEF};
      endcase
   endfunction

   function automatic string slot_text(input int n);
      case (n)
         1:       return "SRC_1:1234ABCD";
         3:       return "AB   :00000000";
         default: return "              ";
      endcase
   endfunction

   // ---------------- DUT 1: 4 slots, RESP_LAT 1 ----------------
   logic        scan_en = 1'b0;
   logic [5:0]  display_number;
   logic        display_valid;
   logic [39:0] display_name;
   logic [31:0] display_value;
   logic        char_valid;
   logic        char_ready = 1'b1;
   logic [7:0]  char_code;
   logic [5:0]  char_slot;
   logic [3:0]  char_pos;
   logic        frame_done;
   logic        busy;

   assign {display_valid, display_name, display_value} = user_ans(display_number);

   display_scanner #(.NUM_SLOTS(4), .RESP_LAT(1)) dut (
      .clk(clk), .reset(reset), .scan_en(scan_en),
      .display_number(display_number), .display_valid(display_valid),
      .display_name(display_name), .display_value(display_value),
      .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code),
      .char_slot(char_slot), .char_pos(char_pos),
      .frame_done(frame_done), .busy(busy)
   );

   // ---------------- DUT 2: 2 slots, RESP_LAT 3 ----------------
   logic        scan_en2 = 1'b0;
   logic [5:0]  dn2;
   logic        dv2;
   logic [39:0] dname2;
   logic [31:0] dval2;
   logic        cv2;
   logic        cready2 = 1'b1;
   logic [7:0]  ccode2;
   logic [5:0]  cslot2;
   logic [3:0]  cpos2;
   logic        fd2;
   logic        busy2;
   int          lat2 = 3;
   logic [5:0]  dpipe [1:4];

   // user logic whose answer lags display_number by lat2 cycles
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i <= 4; i++) dpipe[i] <= 6'd0;
      end else begin
         dpipe[1] <= dn2;
         dpipe[2] <= dpipe[1];
         dpipe[3] <= dpipe[2];
         dpipe[4] <= dpipe[3];
      end
   end
   assign {dv2, dname2, dval2} = user_ans((lat2 == 3) ? dpipe[3] : dpipe[4]);

   display_scanner #(.NUM_SLOTS(2), .RESP_LAT(3)) dut2 (
      .clk(clk), .reset(reset), .scan_en(scan_en2),
      .display_number(dn2), .display_valid(dv2),
      .display_name(dname2), .display_value(dval2),
      .char_valid(cv2), .char_ready(cready2), .char_code(ccode2),
      .char_slot(cslot2), .char_pos(cpos2),
      .frame_done(fd2), .busy(busy2)
   );

   // ---------------- ready driver and monitors ----------------
   logic rand_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   xfer_t q1[$];
   xfer_t q2[$];
   int    fd_count    = 0;
   int    stall_total = 0;
   int    stall_bad   = 0;
   logic  prev_stall  = 1'b0;
   logic [17:0] stall_snap = '0;

   always @(negedge clk) begin
      if (!reset && char_valid && char_ready)
         q1.push_back('{char_slot, char_pos, char_code, cyc});
      if (!reset && cv2 && cready2)
         q2.push_back('{cslot2, cpos2, ccode2, cyc});
      if (frame_done) fd_count++;
      if (prev_stall && (!char_valid || {char_slot, char_pos, char_code} != stall_snap))
         stall_bad++;
      if (!reset && char_valid && !char_ready) begin
         stall_total++;
         prev_stall = 1'b1;
         stall_snap = {char_slot, char_pos, char_code};
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   vec_t exp1[56];
   vec_t exp2[28];
   int   c0, cf, s0, s1, bad;
   logic ok;
   string t;

   initial begin
      for (int s = 0; s < 4; s++) begin
         t = slot_text(s + 1);
         for (int p = 0; p < 14; p++) exp1[s*14 + p] = '{6'(s + 1), 4'(p), t[p]};
      end
      for (int s = 0; s < 2; s++) begin
         t = slot_text(s + 1);
         for (int p = 0; p < 14; p++) exp2[s*14 + p] = '{6'(s + 1), 4'(p), t[p]};
      end

      // reset values
      repeat (3) @(negedge clk);
      check("rst_display_number", 32'(display_number), 0);
      check("rst_char_valid", 32'(char_valid), 0);
      check("rst_char_code", 32'(char_code), 0);
      check("rst_char_slot", 32'(char_slot), 0);
      check("rst_char_pos", 32'(char_pos), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_busy", 32'(busy), 0);
      reset = 1'b0;

      // ---- test 1: single frame, ready tied high, scan_en dropped mid-frame
      @(negedge clk);
      scan_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) begin ok = 1'b1; break; end
      end
      check("t1_busy_start", 32'(ok), 1);
      c0 = cyc;
      check("t1_req_display_number", 32'(display_number), 0);
      scan_en = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_done) begin ok = 1'b1; break; end
      end
      check("t1_frame_done_seen", 32'(ok), 1);
      cf = cyc;
      check("t1_frame_cycles", 32'(cf - c0), 68);
      check("t1_busy_at_done", 32'(busy), 0);
      check("t1_char_count", 32'(q1.size()), 56);
      if (q1.size() >= 14) begin
         check("t1_first_char_cycle", 32'(q1[0].cyc - c0), 3);
         check("t1_slot1_back_to_back", 32'(q1[13].cyc - q1[0].cyc), 13);
      end
      for (int i = 0; i < 56; i++) begin
         if (i < q1.size())
            check($sformatf("t1_char%0d", i), {14'd0, q1[i].slot, q1[i].pos, q1[i].code},
                  {14'd0, exp1[i].slot, exp1[i].pos, exp1[i].code});
      end
      repeat (10) @(negedge clk);
      check("t1_no_restart_busy", 32'(busy), 0);
      check("t1_no_restart_dn", 32'(display_number), 0);
      check("t1_frame_done_once", 32'(fd_count), 1);

      // ---- test 2: random backpressure, scan_en held for back-to-back frames
      q1.delete();
      rand_ready = 1'b1;
      scan_en    = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) begin ok = 1'b1; break; end
      end
      check("t2_busy_start", 32'(ok), 1);
      c0 = cyc;
      s0 = stall_total;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (frame_done) begin ok = 1'b1; break; end
      end
      check("t2_frame_done_seen", 32'(ok), 1);
      cf = cyc;
      s1 = stall_total;
      check("t2_stalls_happened", 32'(s1 > s0), 1);
      check("t2_frame_cycles", 32'(cf - c0), 32'(68 + s1 - s0));
      check("t2_stall_stability", 32'(stall_bad), 0);
      check("t2_char_count", 32'(q1.size()), 56);
      bad = 0;
      for (int i = 0; i < 56; i++) begin
         if (i >= q1.size() || q1[i].slot != exp1[i].slot || q1[i].pos != exp1[i].pos ||
             q1[i].code != exp1[i].code) bad++;
      end
      check("t2_stream_matches", 32'(bad), 0);
      @(negedge clk);
      check("t2_restart_busy", 32'(busy), 1);
      check("t2_restart_gap", 32'(cyc - cf), 1);
      rand_ready = 1'b0;

      // ---- test 3: reset mid-EMIT at slot 2, pos 7
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (char_valid && char_slot == 6'd2 && char_pos == 4'd7) begin ok = 1'b1; break; end
      end
      check("t3_reached_slot2_pos7", 32'(ok), 1);
      reset = 1'b1;
      @(negedge clk);
      check("t3_rst_char_valid", 32'(char_valid), 0);
      check("t3_rst_display_number", 32'(display_number), 0);
      check("t3_rst_busy", 32'(busy), 0);
      check("t3_rst_char_pos", 32'(char_pos), 0);
      reset = 1'b0;
      q1.delete();
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (q1.size() > 0) begin ok = 1'b1; break; end
      end
      check("t3_restart_char_seen", 32'(ok), 1);
      if (q1.size() > 0)
         check("t3_restart_first_char", {14'd0, q1[0].slot, q1[0].pos, q1[0].code},
               {14'd0, 6'd1, 4'd0, 8'h53});
      scan_en = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_done) begin ok = 1'b1; break; end
      end
      check("t3_frame_completes", 32'(ok), 1);

      // ---- test 4: RESP_LAT 3 with a matching 3-cycle user model
      q2.delete();
      lat2     = 3;
      scan_en2 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy2) begin ok = 1'b1; break; end
      end
      check("t4_busy_start", 32'(ok), 1);
      c0 = cyc;
      scan_en2 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (fd2) begin ok = 1'b1; break; end
      end
      check("t4_frame_done_seen", 32'(ok), 1);
      cf = cyc;
      check("t4_frame_cycles", 32'(cf - c0), 38);
      check("t4_char_count", 32'(q2.size()), 28);
      if (q2.size() > 0) check("t4_first_char_cycle", 32'(q2[0].cyc - c0), 5);
      for (int i = 0; i < 28; i++) begin
         if (i < q2.size())
            check($sformatf("t4_char%0d", i), {14'd0, q2[i].slot, q2[i].pos, q2[i].code},
                  {14'd0, exp2[i].slot, exp2[i].pos, exp2[i].code});
      end

      // ---- test 5: user model slower than RESP_LAT captures the previous slot
      lat2 = 4;
      repeat (6) @(negedge clk);
      q2.delete();
      scan_en2 = 1'b1;
      @(negedge clk);
      scan_en2 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (fd2) begin ok = 1'b1; break; end
      end
      check("t5_frame_done_seen", 32'(ok), 1);
      check("t5_char_count", 32'(q2.size()), 28);
      t = slot_text(1);
      bad = 0;
      for (int p = 0; p < 14; p++) begin
         if (14 + p >= q2.size() || q2[14 + p].code != t[p] || q2[14 + p].slot != 6'd2) bad++;
      end
      check("t5_slot2_stale_capture", 32'(bad), 0);
      t = slot_text(2);
      bad = 0;
      for (int p = 0; p < 14; p++) begin
         if (p >= q2.size() || q2[p].code != t[p]) bad++;
      end
      check("t5_slot1_blank", 32'(bad), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
